// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: one free-running frame counter produces mclk/sclk/lrck,
// and a holding register plus a frame register serialise one stereo pair per frame.
module i2s_tx_ctrl #(
   parameter int DATA_W        = 16,
   parameter int MCLK_DIV_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   output logic              mclk,
   output logic              sclk,
   output logic              lrck,
   output logic              sdata,
   output logic              frame_start,
   output logic              underrun,
   input  logic              underrun_clr
);
   localparam int CNT_W    = MCLK_DIV_LOG2 + 8;
   localparam int SCLK_BIT = MCLK_DIV_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hold_full_q, hold_full_d;
   logic [DATA_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [DATA_W-1:0]   frame_l_q, frame_l_d, frame_r_q, frame_r_d;
   logic                sdata_q, sdata_d;
   logic                underrun_q, underrun_d;
   logic                load;
   logic                xfer;
   logic                cnt_last;
   logic [4:0]          slot_k;
   logic [DATA_W-1:0]   slot_word;
   logic                slot_bit;

   assign s_ready     = !hold_full_q && !rst;
   assign xfer        = s_valid && s_ready;
   assign frame_start = load && !rst;
   assign cnt_last    = &cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (cnt_last) begin
               if (en) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if (!en) begin
               state_d = STOP;
            end
         end
         STOP: begin
            // Re-enabling resumes without a gap; a frame boundary still loads.
            if (en) begin
               state_d = RUN;
               load    = cnt_last;
            end else if (cnt_last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      frame_l_d   = frame_l_q;
      frame_r_d   = frame_r_q;
      underrun_d  = underrun_q;
      if (load) begin
         hold_full_d = 1'b0;
         frame_l_d   = hold_full_q ? hold_l_q : '0;
         frame_r_d   = hold_full_q ? hold_r_q : '0;
      end
      // A transfer alongside a load refills the holding register for the next frame.
      if (xfer) begin
         hold_full_d = 1'b1;
         hold_l_d    = s_left;
         hold_r_d    = s_right;
      end
      if (underrun_clr) underrun_d = 1'b0;
      if (load && !hold_full_q) underrun_d = 1'b1;
   end

   // Bit for the slot position the counter is about to enter; k=0 and k>DATA_W stay 0.
   always_comb begin
      slot_k    = cnt_d[SCLK_BIT+5:SCLK_BIT+1];
      slot_word = cnt_d[CNT_W-1] ? frame_r_q : frame_l_q;
      slot_bit  = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (int'(slot_k) == DATA_W - i) slot_bit = slot_word[i];
      end
      sdata_d = sdata_q;
      if (cnt_d[SCLK_BIT:0] == '0) sdata_d = slot_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         frame_l_q   <= '0;
         frame_r_q   <= '0;
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         frame_l_q   <= frame_l_d;
         frame_r_q   <= frame_r_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
      end
   end

   assign mclk     = cnt_q[MCLK_DIV_LOG2-1];
   assign sclk     = cnt_q[SCLK_BIT];
   assign lrck     = cnt_q[CNT_W-1];
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: every frame is compared against an I2S
// bit-stream model computed from the frame offset and the pair expected in it.
`timescale 1ns/1ps
module tb_i2s_tx_ctrl;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          s_valid = 1'b0;
   logic          underrun_clr = 1'b0;
   logic [DW-1:0] s_left = '0;
   logic [DW-1:0] s_right = '0;
   logic          s_ready, mclk, sclk, lrck, sdata, frame_start, underrun;

   int checks = 0;
   int passed = 0;
   logic [31:0] acc_q[$];

   always #5 clk = ~clk;

   i2s_tx_ctrl #(.DATA_W(DW), .MCLK_DIV_LOG2(3)) dut (
      .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
      .s_left(s_left), .s_right(s_right), .mclk(mclk), .sclk(sclk), .lrck(lrck),
      .sdata(sdata), .frame_start(frame_start), .underrun(underrun),
      .underrun_clr(underrun_clr)
   );

   initial begin
      #2ms;
      $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passed);
      $fatal(1, "watchdog");
   end

   // Expected serial bit at frame offset j (sampled on the sclk rising edge).
   function automatic logic exp_sdata(input logic [DW-1:0] l, input logic [DW-1:0] r, input int j);
      int k;
      logic [DW-1:0] w;
      w = (j >= 1024) ? r : l;
      k = (j % 1024) / 32;
      if (k >= 1 && k <= DW) return w[DW-k];
      return 1'b0;
   endfunction

   // Entered at the negedge of the load cycle; returns at the negedge of offset 2047.
   task automatic check_frame(input string name, input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int en_off, input int en_on, input logic do_push,
                              input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                              input logic drop_at0, input logic fs_end);
      int clk_err;
      logic [63:0] got, want;
      clk_err = 0;
      got = '0;
      want = '0;
      for (int j = 0; j < 2048; j++) begin
         @(negedge clk);
         if (drop_at0 && j == 0) begin
            s_valid = 1'b0;
            underrun_clr = 1'b0;
         end
         if ({mclk, sclk, lrck} !== {1'((j / 4) % 2), 1'((j / 16) % 2), 1'(j / 1024)}) clk_err++;
         if (j < 2047 && frame_start !== 1'b0) clk_err++;
         if (j % 32 == 16) begin
            got[j/32]  = sdata;
            want[j/32] = exp_sdata(l, r, j);
         end
         if (j == en_off) en = 1'b0;
         if (j == en_on) en = 1'b1;
         if (do_push && j == 100) begin
            checks++;
            if (s_ready !== 1'b1) $display("FAIL %s_ready got %b want 1", name, s_ready);
            else passed++;
            s_valid = 1'b1;
            s_left = pl;
            s_right = pr;
         end
         if (do_push && j == 101) s_valid = 1'b0;
      end
      checks++;
      if (clk_err !== 0) $display("FAIL %s_clocks bad cycles got %0d want 0", name, clk_err);
      else passed++;
      checks++;
      if (got !== want) $display("FAIL %s_sdata got %h want %h", name, got, want);
      else passed++;
      checks++;
      if (frame_start !== fs_end) $display("FAIL %s_fs_end got %b want %b", name, frame_start, fs_end);
      else passed++;
      $display("frame %s L=%h R=%h sdata=%h", name, l, r, got);
   endtask

   task automatic prefill(input logic [DW-1:0] l, input logic [DW-1:0] r);
      @(negedge clk);
      s_valid = 1'b1;
      s_left = l;
      s_right = r;
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic start_run(input string name);
      @(negedge clk);
      en = 1'b1;
      #1;
      checks++;
      if (frame_start !== 1'b1) $display("FAIL %s_start got %b want 1", name, frame_start);
      else passed++;
   endtask

   task automatic check_idle(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if ({mclk, sclk, lrck, sdata, frame_start} !== 5'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL %s_idle nonzero cycles got %0d want 0", name, bad);
      else passed++;
      $display("idle %s bad=%0d", name, bad);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready} !== 7'b0)
         $display("FAIL reset_outs got %b want 0000000",
                  {mclk, sclk, lrck, sdata, frame_start, underrun, s_ready});
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, mclk, sclk, lrck, sdata, frame_start, underrun} !== 7'b1000000)
         $display("FAIL reset_release got %b want 1000000",
                  {s_ready, mclk, sclk, lrck, sdata, frame_start, underrun});
      else passed++;
      $display("reset released s_ready=%b", s_ready);
   endtask

   task automatic test_prefill_stop_restart();
      logic [DW-1:0] bl, br;
      bl = DW'($urandom);
      br = DW'($urandom);
      prefill(16'h8001, 16'h7FFE);
      checks++;
      if (s_ready !== 1'b0) $display("FAIL prefill_full got %b want 0", s_ready);
      else passed++;
      start_run("prefill");
      check_frame("prefill_restart", 16'h8001, 16'h7FFE, 500, 900, 1'b1, bl, br, 1'b0, 1'b1);
      check_frame("stop", bl, br, 500, -1, 1'b0, '0, '0, 1'b0, 1'b0);
      check_idle("stop");
      checks++;
      if (underrun !== 1'b0) $display("FAIL stop_underrun got %b want 0", underrun);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] p;
      logic [DW-1:0] fl, fr;
      int n, guard;
      logic prev_fs, pend;
      p = $urandom;
      acc_q.delete();
      prefill(p[31:16], p[15:0]);
      acc_q.push_back(p);
      start_run("b2b");
      fork
         begin
            n = 0;
            guard = 0;
            pend = 1'b0;
            prev_fs = frame_start;
            fl = DW'($urandom);
            fr = DW'($urandom);
            s_left = fl;
            s_right = fr;
            s_valid = 1'b1;
            while (n < 3 && guard < 4 * 2048) begin
               @(negedge clk);
               guard++;
               if (pend) begin
                  fl = DW'($urandom);
                  fr = DW'($urandom);
                  s_left = fl;
                  s_right = fr;
                  pend = 1'b0;
               end
               if (s_valid && s_ready) begin
                  checks++;
                  if (prev_fs !== 1'b1) $display("FAIL b2b_accept_timing prev frame_start got %b want 1", prev_fs);
                  else passed++;
                  acc_q.push_back({fl, fr});
                  $display("xfer %0d L=%h R=%h", n, fl, fr);
                  n++;
                  pend = 1'b1;
               end
               prev_fs = frame_start;
            end
            checks++;
            if (n !== 3) $display("FAIL b2b_xfer_count got %0d want 3", n);
            else passed++;
            @(negedge clk);
            s_valid = 1'b0;
         end
         begin
            for (int f = 0; f < 4; f++) begin
               checks++;
               if (acc_q.size() == 0) begin
                  $display("FAIL b2b_queue frame %0d got empty want pair", f);
                  p = '0;
               end else begin
                  passed++;
                  p = acc_q.pop_front();
               end
               check_frame($sformatf("b2b_f%0d", f), p[31:16], p[15:0],
                           (f == 3) ? 500 : -1, -1, 1'b0, '0, '0, 1'b0, (f < 3));
            end
         end
      join
      check_idle("b2b");
      checks++;
      if (underrun !== 1'b0) $display("FAIL b2b_underrun got %b want 0", underrun);
      else passed++;
   endtask

   task automatic test_underrun();
      logic [DW-1:0] al, ar, pl, pr;
      al = DW'($urandom);
      ar = DW'($urandom);
      pl = DW'($urandom);
      pr = DW'($urandom);
      prefill(al, ar);
      start_run("ur");
      check_frame("ur_f1", al, ar, -1, -1, 1'b0, '0, '0, 1'b0, 1'b1);
      check_frame("ur_f2_zero", '0, '0, 500, -1, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (underrun !== 1'b1) $display("FAIL ur_held got %b want 1", underrun);
      else passed++;
      check_idle("ur");
      @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      checks++;
      if (underrun !== 1'b0) $display("FAIL ur_clear got %b want 0", underrun);
      else passed++;
      @(negedge clk);
      en = 1'b1;
      underrun_clr = 1'b1;
      s_valid = 1'b1;
      s_left = pl;
      s_right = pr;
      #1;
      checks++;
      if ({frame_start, s_ready} !== 2'b11) $display("FAIL ur_coincide_start got %b want 11", {frame_start, s_ready});
      else passed++;
      check_frame("ur_empty_load", '0, '0, -1, -1, 1'b0, '0, '0, 1'b1, 1'b1);
      checks++;
      if (underrun !== 1'b1) $display("FAIL ur_set_over_clr got %b want 1", underrun);
      else passed++;
      check_frame("ur_late_xfer", pl, pr, 500, -1, 1'b0, '0, '0, 1'b0, 1'b0);
      check_idle("ur_late");
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] al, ar;
      int bad;
      al = DW'($urandom);
      ar = DW'($urandom) | 16'h0400;
      prefill(al, ar);
      start_run("arst");
      for (int j = 0; j <= 1234; j++) @(negedge clk);
      checks++;
      if ({lrck, sclk, sdata} !== 3'b111) $display("FAIL arst_pre got %b want 111", {lrck, sclk, sdata});
      else passed++;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({mclk, sclk, lrck, sdata, frame_start, underrun, s_ready} !== 7'b0)
         $display("FAIL arst_immediate got %b want 0000000",
                  {mclk, sclk, lrck, sdata, frame_start, underrun, s_ready});
      else passed++;
      en = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (s_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL arst_ready_held got %0d cycles ready want 0", bad);
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s_ready, mclk, sclk, lrck, sdata, frame_start} !== 6'b100000)
         $display("FAIL arst_release got %b want 100000", {s_ready, mclk, sclk, lrck, sdata, frame_start});
      else passed++;
      $display("async reset at offset 1234 done");
   endtask

   initial begin
      test_reset();
      test_prefill_stop_restart();
      test_back_to_back();
      test_underrun();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/i2s_tx_ctrl.md
I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width per channel (legal 1..31).
REQ-002 SHALL have parameter MCLK_DIV_LOG2, default 3, meaning mclk = clk / 2^3 (12.5 MHz from 100 MHz); other ratios are derived from it per REQ-012.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port s_valid  input  1  upstream sample pair valid.
REQ-007 SHALL have port s_ready  output  1  block can accept a sample pair.
REQ-008 SHALL have port s_left / s_right  input  DATA_W each  signed sample pair, two's complement.
REQ-009 SHALL have ports mclk, sclk, lrck, sdata  output  1 each  DAC master, bit, word-select clocks and serial data.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse on each frame load.
REQ-011 SHALL have ports underrun (output 1, sticky underrun flag) and underrun_clr (input 1, clears flag).

Function
REQ-012 SHALL use one free-running frame counter cnt of width MCLK_DIV_LOG2+8 (11 bits at default); mclk = cnt[2], sclk = cnt[4], lrck = cnt[10] (default bit positions), giving 64 sclk per frame and a frame rate of clk/2048 (48.83 kHz).
REQ-013 SHALL implement states IDLE, RUN, STOP.
REQ-014 IDLE: cnt held 0; mclk, sclk, lrck, sdata = 0; en=1 -> RUN with a frame load in the same cycle.
REQ-015 RUN: cnt increments by 1 every clk, wrapping 2047->0; en=0 -> STOP.
REQ-016 STOP: cnt keeps incrementing; en=1 -> RUN with no gap in the clocks; cnt==2047 with en=0 -> IDLE and cnt=0; the frame in progress always completes.
REQ-017 Frame load SHALL occur on IDLE->RUN, or in RUN when cnt==2047; it copies the holding register into the frame register, clears hold_full, and pulses frame_start for exactly 1 cycle.
REQ-018 If hold_full=0 at a frame load, the frame register SHALL load all zeros and underrun SHALL be set.
REQ-019 Handshake: s_ready = !hold_full && !rst; a transfer occurs when s_valid && s_ready and writes s_left/s_right into the holding register and sets hold_full.
REQ-020 A transfer in the same cycle as an underrunning frame load SHALL fill the holding register for the next frame; it is not bypassed into the current frame.
REQ-021 s_ready SHALL be 1 in IDLE when the holding register is empty, so the first sample pair can be prefilled before en rises.
REQ-022 Slot layout: lrck=0 selects left, lrck=1 selects right; slot bit index k = cnt[9:5] (0..31).
REQ-023 Slot bit k=0 SHALL be 0 (the I2S one-bit delay); k=1..DATA_W SHALL carry sample[DATA_W-k] (MSB first); k>DATA_W SHALL be 0.
REQ-024 sdata SHALL be a register updated only in cycles where cnt[4:0]==0 (sclk falling edge), so it is stable across the sclk rising edge at cnt[4:0]==16.
REQ-025 underrun SHALL be cleared by underrun_clr; a simultaneous set SHALL take priority over the clear.

Reset
REQ-026 While rst=1, the block SHALL be in IDLE with cnt=0, hold_full=0, frame register=0, and mclk=sclk=lrck=sdata=frame_start=underrun=0, s_ready=0.
REQ-027 After rst deasserts, s_ready=1 on the next cycle; asserting rst mid-frame SHALL abort immediately, with no frame completion.

Verification
REQ-028 Prefill: reset, then transfer L=16'h8001, R=16'h7FFE in IDLE, then en=1 -> frame_start pulse, s_ready=1 again, and sdata over the left slot reads 0,1,0..0,1,0..0 (MSB at sclk 1, LSB at sclk 16).
REQ-029 Clock ratios: en=1 for 3 frames -> mclk period 8 clk, sclk period 32 clk, lrck period 2048 clk with 50% duty, and lrck toggling on sclk falling edges.
REQ-030 Underrun: no transfer before the 2nd frame load -> frame 2 sdata all 0 and underrun=1 held; underrun_clr pulse -> 0; a set coinciding with a clear leaves it at 1.
REQ-031 Stop/restart: en=0 at cnt=500 -> the frame completes, IDLE at cnt wrap, and outputs 0; en=0 at 500 then en=1 at 900 -> no clock gap and no extra frame_start.
REQ-032 Back-pressure: s_valid held high with a new pair every transfer -> exactly one transfer per frame, each accepted the cycle after frame_start, and no sample lost.
REQ-033 Async reset: rst asserted at cnt=1234 mid-right-slot -> all outputs 0 without waiting for a clk edge, and s_ready=0 until rst deasserts.
